// File: rtl/komandara_k10_pkg.sv
// Shared K10 core types for the GPR file and its pending-write scoreboard.
package komandara_k10_pkg;

    localparam int unsigned NUM_GPR    = 32;
    localparam int unsigned K10_PEND_W = 2;

    typedef logic [4:0]            gpr_addr_t;
    typedef logic [31:0]           gpr_data_t;
    typedef logic [K10_PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/k10_rf_scoreboard.sv
// Per-register outstanding-write counters with RAW pending flags and issue stall.
module k10_rf_scoreboard
    import komandara_k10_pkg::*;
#(
    parameter int unsigned NREGS  = NUM_GPR,
    parameter int unsigned PEND_W = K10_PEND_W
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  logic [4:0] i_wr_rd,
    input  logic       i_issue_en,
    input  logic [4:0] i_issue_rd,
    input  logic       i_kill_en,
    input  logic [4:0] i_kill_rd,
    input  logic [4:0] i_rs1_addr,
    input  logic [4:0] i_rs2_addr,
    output logic       o_rs1_pending,
    output logic       o_rs2_pending,
    output logic       o_issue_stall
);

    localparam int unsigned EW = PEND_W + 2;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_q    [NREGS];
    logic [PEND_W-1:0] cnt_d    [NREGS];
    logic [PEND_W-1:0] post_dec [NREGS];
    logic [EW-1:0]     sum_ext  [NREGS];
    logic [1:0]        dec_n    [NREGS];
    logic              underflow;

    assign o_issue_stall = !i_rst && i_issue_en && (i_issue_rd != '0)
                           && (cnt_q[i_issue_rd] == CNT_MAX);

    // Issue, writeback and kill are summed; the result saturates at zero.
    always_comb begin
        underflow = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            dec_n[r]   = {1'b0, i_wr_en && (i_wr_rd == gpr_addr_t'(r))}
                       + {1'b0, i_kill_en && (i_kill_rd == gpr_addr_t'(r))};
            sum_ext[r] = {2'b00, cnt_q[r]}
                       + EW'(i_issue_en && !o_issue_stall && (i_issue_rd == gpr_addr_t'(r)));
            if (r == 0) begin
                dec_n[r]   = '0;
                sum_ext[r] = '0;
            end
            cnt_d[r]    = (sum_ext[r] < EW'(dec_n[r])) ? '0
                        : PEND_W'(sum_ext[r] - EW'(dec_n[r]));
            post_dec[r] = ({2'b00, cnt_q[r]} < EW'(dec_n[r])) ? '0
                        : PEND_W'({2'b00, cnt_q[r]} - EW'(dec_n[r]));
            underflow   = underflow || (sum_ext[r] < EW'(dec_n[r]));
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (i_rst) cnt_q[r] <= '0;
            else       cnt_q[r] <= cnt_d[r];
        end
    end

    always_ff @(posedge i_clk) begin
        assert (i_rst || !underflow)
            else $error("k10_rf_scoreboard: pending counter underflow");
    end

    assign o_rs1_pending = !i_rst && (i_rs1_addr != '0) && (post_dec[i_rs1_addr] != '0);
    assign o_rs2_pending = !i_rst && (i_rs2_addr != '0) && (post_dec[i_rs2_addr] != '0);

endmodule

// File: rtl/k10_regfile.sv
// RV32 integer register file with two combinational read ports and RAW scoreboard.
// Define K10_RF_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module k10_regfile
    import komandara_k10_pkg::*;
#(
    parameter int unsigned NREGS  = NUM_GPR,
    parameter int unsigned PEND_W = K10_PEND_W
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rf_wr_en,
    input  logic [4:0]  i_rf_rd_addr,
    input  logic [31:0] i_rf_rd_data,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_issue_en,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_kill_en,
    input  logic [4:0]  i_kill_rd,
    output logic        o_rs1_pending,
    output logic        o_rs2_pending,
    output logic        o_issue_stall
);

    gpr_data_t regs [NREGS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (i_rf_wr_en && (i_rf_rd_addr != '0)) begin
            regs[i_rf_rd_addr] <= i_rf_rd_data;
        end
    end

    always_comb begin
        o_rs1_data = regs[i_rs1_addr];
        o_rs2_data = regs[i_rs2_addr];
`ifdef K10_RF_BYPASS_EN
        if (i_rf_wr_en && (i_rf_rd_addr == i_rs1_addr)) o_rs1_data = i_rf_rd_data;
        if (i_rf_wr_en && (i_rf_rd_addr == i_rs2_addr)) o_rs2_data = i_rf_rd_data;
`endif
        // x0 and the reset cycle read as zero regardless of array contents.
        if (i_rst || (i_rs1_addr == '0)) o_rs1_data = '0;
        if (i_rst || (i_rs2_addr == '0)) o_rs2_data = '0;
    end

    k10_rf_scoreboard #(
        .NREGS  (NREGS),
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wr_en       (i_rf_wr_en),
        .i_wr_rd       (i_rf_rd_addr),
        .i_issue_en    (i_issue_en),
        .i_issue_rd    (i_issue_rd),
        .i_kill_en     (i_kill_en),
        .i_kill_rd     (i_kill_rd),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .o_rs1_pending (o_rs1_pending),
        .o_rs2_pending (o_rs2_pending),
        .o_issue_stall (o_issue_stall)
    );

endmodule
